// File: rtl/seq_pkg.sv
// Shared types and default parameters for the serial pattern generator.
package seq_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 0;

endpackage

// File: rtl/seq_gen_shreg.sv
// MSB-first shift register with a capture copy so the pattern can be replayed.
module seq_gen_shreg #(
  parameter int WIDTH = seq_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] sh;

  // Capture/reload/shift; zeros shift in so the register empties after the last bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap <= '0;
      sh  <= '0;
    end else if (load) begin
      cap <= din;
      sh  <= din;
    end else if (reload) begin
      sh <= cap;
    end else if (shift) begin
      sh <= {sh[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sh[WIDTH-1];

endmodule

// File: rtl/seq_generator.sv
// Serial pattern generator: sends a captured pattern MSB first, reps times,
// with optional idle gap cycles between repetitions.
module seq_generator
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  output logic             out,
  output logic             out_vld,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  seq_state_t       state;
  logic [BW-1:0]    bitcnt;
  logic [3:0]       gapcnt;
  logic [CNT_W-1:0] repcnt;
  logic             ld;
  logic             rld;
  logic             shf;
  logic             accept;
  logic             last_bit;
  logic             more;

  assign accept   = (state == ST_IDLE) && start;
  assign last_bit = (state == ST_SHIFT) && (bitcnt == BIT_LAST);
  assign more     = repcnt > ONE;

  // Shift-register control decoded from the current state
  always_comb begin
    ld  = accept;
    rld = 1'b0;
    shf = 1'b0;
    if (state == ST_SHIFT) begin
      if (last_bit && more && (GAP == 0)) rld = 1'b1;
      else                                shf = 1'b1;
    end else if ((state == ST_GAP) && (gapcnt == GAP_LAST)) begin
      rld = 1'b1;
    end
  end

  // FSM, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bitcnt  <= '0;
      gapcnt  <= '0;
      repcnt  <= '0;
      out_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_SHIFT;
            bitcnt  <= '0;
            repcnt  <= (reps == '0) ? ONE : reps;
            out_vld <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (bitcnt == BIT_LAST) begin
            bitcnt <= '0;
            if (repcnt != '0) repcnt <= repcnt - ONE;
            if (more) begin
              if (GAP > 0) begin
                state   <= ST_GAP;
                gapcnt  <= '0;
                out_vld <= 1'b0;
              end
            end else begin
              state   <= ST_DONE;
              out_vld <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            bitcnt <= bitcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gapcnt == GAP_LAST) begin
            state   <= ST_SHIFT;
            gapcnt  <= '0;
            out_vld <= 1'b1;
          end else begin
            gapcnt <= gapcnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  seq_gen_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load   (ld),
    .reload (rld),
    .shift  (shf),
    .din    (pattern),
    .msb    (out)
  );

endmodule
